// File: rtl/seg_display_scan_pkg.sv
// rtl/seg_display_scan_pkg.sv - shared display constants, slot index type and anode decode helper
// Exports:
//   SEG_OFF / AN_OFF : all-off (active-low) cathode and anode patterns
//   NUM_DIGITS       : digits on the display
//   SLOT_W           : width of the slot index
//   slot_idx_t       : slot index type
//   an_onehot_low()  : slot index to single active-low anode enable
package seg_display_scan_pkg;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam int         NUM_DIGITS = 4;
  localparam int         SLOT_W     = 2;

  typedef logic [SLOT_W-1:0] slot_idx_t;

  function automatic logic [3:0] an_onehot_low(input slot_idx_t s);
    return ~(4'b0001 << s);
  endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - digit slot timer: slot counter, slot index, blank flag, frame strobes
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   slot         : current slot index (0 = ones .. 3 = thousands)
//   blank        : current cycle lies in the blank phase of its slot
//   slot_start   : current cycle is the first cycle of a slot
//   frame_start  : current cycle is the first cycle of slot 0
//   frame_end    : current cycle is the last cycle of slot 3
// Strobes describe the cycle ending at the next rising edge, so a register
// loaded from them takes effect exactly on that edge.
module seg_scan_timer
  import seg_display_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      rst_n,
  output slot_idx_t slot,
  output logic      blank,
  output logic      slot_start,
  output logic      frame_start,
  output logic      frame_end
);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      slot <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt  <= '0;
      slot <= slot + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign blank       = (cnt < CW'(BLANK_CYCLES));
  assign slot_start  = (cnt == '0);
  assign frame_start = slot_start && (slot == '0);
  assign frame_end   = (cnt == CW'(SCAN_DIV - 1)) && (slot == slot_idx_t'(NUM_DIGITS - 1));
endmodule

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - four-digit multiplexed seven-segment driver with blanking, frame latch and blink
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   thousands/hundreds/tens/ones_segs   : active-low segment bytes, digits 3..0
//   blink_mask                          : bit i set makes digit i blink
//   seg                                 : registered active-low cathode bus
//   an                                  : registered active-low anode enables, an[0] = ones
//   frame_tick                          : one-cycle pulse following each frame start
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] thousands_segs,
  input  logic [7:0] hundreds_segs,
  input  logic [7:0] tens_segs,
  input  logic [7:0] ones_segs,
  input  logic [3:0] blink_mask,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  slot_idx_t     slot;
  logic          blank;
  logic          slot_start;
  logic          frame_start;
  logic          frame_end;

  logic [7:0]    shadow [NUM_DIGITS];
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          hide_q;

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot        (slot),
    .blank       (blank),
    .slot_start  (slot_start),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_tick  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= SEG_OFF;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      hide_q      <= 1'b0;
    end else begin
      frame_tick <= frame_start;

      if (frame_start) begin
        shadow[0] <= ones_segs;
        shadow[1] <= tens_segs;
        shadow[2] <= hundreds_segs;
        shadow[3] <= thousands_segs;
      end

      // Toggling on the last edge of a frame makes the new phase visible
      // from the very first cycle of the next frame's slot 0.
      if (frame_end) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      // The blink decision is frozen for the whole slot; the slot's first
      // cycle is always blank, so the stale hide_q is never visible there.
      if (slot_start) hide_q <= blink_phase & blink_mask[slot];

      if (blank || hide_q) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end else begin
        an  <= an_onehot_low(slot);
        seg <= shadow[slot];
      end
    end
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - directed and invariant bench for seg_display_scan
module tb_seg_display_scan;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_b [4];
  logic [3:0] blink_mask;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  int ecount = 0;
  logic [7:0] sh [4];

  always #5 clk = ~clk;

  seg_display_scan #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .thousands_segs (in_b[3]),
    .hundreds_segs  (in_b[2]),
    .tens_segs      (in_b[1]),
    .ones_segs      (in_b[0]),
    .blink_mask     (blink_mask),
    .seg            (seg),
    .an             (an),
    .frame_tick     (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, ecount, obs, exp);
    end
  endtask

  // Runs n edges, predicting every output from edge number, inputs and mask.
  task automatic run_edges(input int n);
    int pos, slot, frame;
    logic hide;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ecount++;
      pos   = (ecount - 1) % SD;
      slot  = ((ecount - 1) / SD) % 4;
      frame = (ecount - 1) / (4 * SD);
      if (pos == 0 && slot == 0)
        for (int k = 0; k < 4; k++) sh[k] = in_b[k];
      hide = (((frame / BF) % 2) == 1) && blink_mask[slot];
      #1;
      if (pos < BC || hide) begin
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        exp_seg = sh[slot];
      end
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("frame_tick", 32'(frame_tick), 32'(pos == 0 && slot == 0));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg), 32'h000000FF);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
  endtask

  initial begin
    int last_an, off_run, zeros;
    in_b[0] = 8'hC0; in_b[1] = 8'hF9; in_b[2] = 8'hA4; in_b[3] = 8'hB0;
    blink_mask = 4'b0000;

    // Reset and basic scan, then tear-free latch of a mid-frame change.
    do_reset();
    run_edges(12);
    in_b[0] = 8'h92;
    run_edges(52);

    // Blink on tens: frames 0-1 visible, 2-3 hidden, 4 visible.
    in_b[0] = 8'hC0;
    blink_mask = 4'b0010;
    do_reset();
    run_edges(5 * 4 * SD);

    // Asynchronous reset in the middle of a drive phase.
    blink_mask = 4'b0000;
    do_reset();
    run_edges(13);
    chk("pre_async_an", 32'(an), 32'h0000000D);
    #1 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'h0000000F);
    chk("async_seg", 32'(seg), 32'h000000FF);
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
    run_edges(4 * SD);

    // Anode invariants under random inputs and mask.
    last_an = -1;
    off_run = 0;
    for (int c = 0; c < 1000 * 4 * SD; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) in_b[$urandom_range(0, 3)] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) blink_mask = 4'($urandom);
      zeros = 0;
      for (int b = 0; b < 4; b++) if (!an[b]) zeros++;
      chk("onehot", 32'(zeros <= 1), 32'h1);
      if (an == 4'hF) begin
        off_run++;
      end else begin
        if (last_an != -1 && int'(an) != last_an)
          chk("gap", 32'(off_run >= BC), 32'h1);
        last_an = int'(an);
        off_run = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
